// File: rtl/clock_set_controller_if.sv
// Button inputs and edit-command outputs between the board front end and the clock set controller.
// master drives the raw buttons and the ms tick; slave is the controller.
interface clock_set_controller_if;
    logic       i_ms_pulse;
    logic       i_set;
    logic       i_up;
    logic       i_down;
    logic       i_left;
    logic       i_right;
    logic       o_set_mode;
    logic [1:0] o_field;
    logic       o_inc;
    logic       o_dec;
    logic       o_commit;
    logic       o_blink;

    modport master (
        output i_ms_pulse, i_set, i_up, i_down, i_left, i_right,
        input  o_set_mode, o_field, o_inc, o_dec, o_commit, o_blink
    );

    modport slave (
        input  i_ms_pulse, i_set, i_up, i_down, i_left, i_right,
        output o_set_mode, o_field, o_inc, o_dec, o_commit, o_blink
    );
endinterface

// File: rtl/clock_set_controller.sv
// Time-set front end: sync/debounce buttons, RUN/EDIT/COMMIT mode FSM, cursor and inc/dec pulses.
// Latency: 2 sync cycles + DEBOUNCE_MS ticks to debounce; commands register one cycle after the debounced edge.
// No backpressure: outputs are single-cycle pulses. Define AUTO_REPEAT_EN for held up/down auto-repeat.
module clock_set_controller #(
    parameter int DEBOUNCE_MS = 4,
    parameter int HOLD_MS     = 500,
    parameter int REPEAT_MS   = 100,
    parameter int BLINK_MS    = 250,
    parameter int CNT_W       = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    clock_set_controller_if.slave  bus
);
    localparam int NB    = 5;
    localparam int B_SET = 0;
    localparam int B_UP  = 1;
    localparam int B_DN  = 2;
    localparam int B_LF  = 3;
    localparam int B_RT  = 4;

    typedef enum logic [1:0] {ST_RUN, ST_EDIT, ST_COMMIT} state_t;

    logic [NB-1:0]    raw;
    logic [NB-1:0]    meta_q, meta_d, sync_q, sync_d;
    logic [NB-1:0]    deb_q, deb_d, deb_dly_q, deb_dly_d;
    logic [CNT_W-1:0] dcnt_q [NB];
    logic [CNT_W-1:0] dcnt_d [NB];

    state_t           state_q, state_d;
    logic [1:0]       field_q, field_d;
    logic             set_mode_q, set_mode_d;
    logic             inc_q, inc_d, dec_q, dec_d, commit_q, commit_d;
    logic             blink_q, blink_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic             block_q, block_d;

    logic [NB-1:0]    rise;
    logic             set_fall, ud_conflict, up_ev, dn_ev;
    logic             mv_left, mv_right, cursor_mv;
    logic             rep_inc, rep_dec;

    assign raw = {bus.i_right, bus.i_left, bus.i_down, bus.i_up, bus.i_set};

    always_comb begin
        meta_d    = raw;
        sync_d    = meta_q;
        deb_dly_d = deb_q;
        deb_d     = deb_q;
        for (int i = 0; i < NB; i++) begin
            dcnt_d[i] = dcnt_q[i];
            if (sync_q[i] == deb_q[i]) begin
                dcnt_d[i] = '0;
            end else if (bus.i_ms_pulse) begin
                if (dcnt_q[i] >= CNT_W'(DEBOUNCE_MS - 1)) begin
                    deb_d[i]  = sync_q[i];
                    dcnt_d[i] = '0;
                end else begin
                    dcnt_d[i] = dcnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    assign rise     = deb_q & ~deb_dly_q;
    assign set_fall = deb_dly_q[B_SET] & ~deb_q[B_SET];

    // Covers both keys rising together and one rising while the other is already held.
    assign ud_conflict = (rise[B_UP] & deb_q[B_DN]) | (rise[B_DN] & deb_q[B_UP]);
    assign up_ev       = rise[B_UP] & ~ud_conflict & ~block_q;
    assign dn_ev       = rise[B_DN] & ~ud_conflict & ~block_q;
    assign mv_left     = rise[B_LF] & ~rise[B_RT];
    assign mv_right    = rise[B_RT] & ~rise[B_LF];
    assign cursor_mv   = (state_q == ST_EDIT) & ~set_fall & (mv_left | mv_right);

    always_comb begin
        block_d = block_q;
        if (!deb_q[B_UP] && !deb_q[B_DN]) begin
            block_d = 1'b0;
        end else if (ud_conflict) begin
            block_d = 1'b1;
        end
    end

`ifdef AUTO_REPEAT_EN
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d, rep_cnt_q, rep_cnt_d;
    logic             hold_active, rep_fire;

    assign hold_active = (state_q == ST_EDIT) & (deb_q[B_UP] ^ deb_q[B_DN]) & ~block_q & ~ud_conflict;

    always_comb begin
        hold_cnt_d = hold_cnt_q;
        rep_cnt_d  = rep_cnt_q;
        rep_fire   = 1'b0;
        if (!hold_active || cursor_mv) begin
            hold_cnt_d = '0;
            rep_cnt_d  = '0;
        end else if (bus.i_ms_pulse) begin
            if (hold_cnt_q < CNT_W'(HOLD_MS)) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
                rep_fire   = (hold_cnt_q == CNT_W'(HOLD_MS - 1));
            end else if (rep_cnt_q >= CNT_W'(REPEAT_MS - 1)) begin
                rep_cnt_d = '0;
                rep_fire  = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_cnt_q <= '0;
            rep_cnt_q  <= '0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            rep_cnt_q  <= rep_cnt_d;
        end
    end

    assign rep_inc = rep_fire & deb_q[B_UP];
    assign rep_dec = rep_fire & deb_q[B_DN];
`else
    localparam int unused_repeat_cfg = HOLD_MS + REPEAT_MS;
    assign rep_inc = 1'b0;
    assign rep_dec = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        field_d  = field_q;
        inc_d    = 1'b0;
        dec_d    = 1'b0;
        commit_d = 1'b0;
        blink_d  = 1'b1;
        bcnt_d   = '0;
        unique case (state_q)
            ST_RUN: begin
                if (rise[B_SET]) begin
                    state_d = ST_EDIT;
                    field_d = 2'd0;
                end
            end
            ST_EDIT: begin
                if (set_fall) begin
                    // Leaving EDIT takes priority over any key event in the same cycle.
                    state_d  = ST_COMMIT;
                    commit_d = 1'b1;
                end else begin
                    blink_d = blink_q;
                    bcnt_d  = bcnt_q;
                    if (mv_left) begin
                        field_d = (field_q == 2'd2) ? 2'd0 : field_q + 2'd1;
                    end else if (mv_right) begin
                        field_d = (field_q == 2'd0) ? 2'd2 : field_q - 2'd1;
                    end
                    if (cursor_mv) begin
                        blink_d = 1'b1;
                        bcnt_d  = '0;
                    end else if (bus.i_ms_pulse) begin
                        if (bcnt_q >= CNT_W'(BLINK_MS - 1)) begin
                            blink_d = ~blink_q;
                            bcnt_d  = '0;
                        end else begin
                            bcnt_d = bcnt_q + CNT_W'(1);
                        end
                    end
                    inc_d = up_ev | rep_inc;
                    dec_d = dn_ev | rep_dec;
                end
            end
            ST_COMMIT: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
        set_mode_d = (state_d == ST_EDIT);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            meta_q     <= '0;
            sync_q     <= '0;
            deb_q      <= '0;
            deb_dly_q  <= '0;
            for (int i = 0; i < NB; i++) dcnt_q[i] <= '0;
            state_q    <= ST_RUN;
            field_q    <= 2'd0;
            set_mode_q <= 1'b0;
            inc_q      <= 1'b0;
            dec_q      <= 1'b0;
            commit_q   <= 1'b0;
            blink_q    <= 1'b1;
            bcnt_q     <= '0;
            block_q    <= 1'b0;
        end else begin
            meta_q     <= meta_d;
            sync_q     <= sync_d;
            deb_q      <= deb_d;
            deb_dly_q  <= deb_dly_d;
            for (int i = 0; i < NB; i++) dcnt_q[i] <= dcnt_d[i];
            state_q    <= state_d;
            field_q    <= field_d;
            set_mode_q <= set_mode_d;
            inc_q      <= inc_d;
            dec_q      <= dec_d;
            commit_q   <= commit_d;
            blink_q    <= blink_d;
            bcnt_q     <= bcnt_d;
            block_q    <= block_d;
        end
    end

    assign bus.o_set_mode = set_mode_q;
    assign bus.o_field    = field_q;
    assign bus.o_inc      = inc_q;
    assign bus.o_dec      = dec_q;
    assign bus.o_commit   = commit_q;
    assign bus.o_blink    = blink_q;
endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller: expected pulses/cursor moves are queued at stimulus time
// and compared as the DUT produces them; ms tick every 3 clocks.
module tb_clock_set_controller;
    localparam int EV_FIELD  = 0;
    localparam int EV_INC    = 1;
    localparam int EV_DEC    = 2;
    localparam int EV_COMMIT = 3;
    localparam int EV_NONE   = 9;
`ifdef AUTO_REPEAT_EN
    localparam int HOLD_PULSES = 5;
`else
    localparam int HOLD_PULSES = 1;
`endif

    typedef struct { int kind; int val; } ev_t;

    logic i_clk = 1'b0;
    logic i_rst;
    ev_t  exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   tick_cnt = 0;
    int   phase = 0;
    int   n;
    logic [1:0] prev_field = 2'd0;

    always #5 i_clk = ~i_clk;

    clock_set_controller_if bus ();

    clock_set_controller #(
        .DEBOUNCE_MS(4), .HOLD_MS(20), .REPEAT_MS(5), .BLINK_MS(8), .CNT_W(16)
    ) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void expect_ev(input int kind, input int val);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        exp_q.push_back(e);
    endfunction

    task automatic monitor();
        int  kind;
        ev_t e;
        if (i_rst) begin
            prev_field = bus.o_field;
            return;
        end
        if (bus.o_inc || bus.o_dec || bus.o_commit) begin
            kind = bus.o_commit ? EV_COMMIT : (bus.o_inc ? EV_INC : EV_DEC);
            check("inc_dec_exclusive", 32'(bus.o_inc & bus.o_dec), 0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", kind, EV_NONE);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", kind, e.kind);
                check("pulse_field", 32'(bus.o_field), e.val);
            end
            if (bus.o_commit) check("commit_set_mode", 32'(bus.o_set_mode), 0);
        end
        if (bus.o_field !== prev_field) begin
            if (exp_q.size() == 0) begin
                check("unexpected_field_move", EV_FIELD, EV_NONE);
            end else begin
                e = exp_q.pop_front();
                check("field_event_kind", EV_FIELD, e.kind);
                check("field_value", 32'(bus.o_field), e.val);
            end
            check("blink_reload_on_move", 32'(bus.o_blink), 1);
        end
        prev_field = bus.o_field;
    endtask

    task automatic cyc();
        @(negedge i_clk);
        if (bus.i_ms_pulse) tick_cnt++;
        monitor();
        phase = (phase == 2) ? 0 : phase + 1;
        bus.i_ms_pulse = (phase == 0);
    endtask

    task automatic wait_ticks(input int t);
        int t0 = tick_cnt;
        while (tick_cnt - t0 < t) cyc();
    endtask

    task automatic wait_mode(input logic want, input int budget, output int cnt);
        cnt = 0;
        while (bus.o_set_mode !== want && cnt < budget) begin
            cyc();
            cnt++;
        end
    endtask

    task automatic press(input logic up, input logic dn, input logic lf, input logic rt);
        bus.i_up = up; bus.i_down = dn; bus.i_left = lf; bus.i_right = rt;
        wait_ticks(7);
        bus.i_up = 1'b0; bus.i_down = 1'b0; bus.i_left = 1'b0; bus.i_right = 1'b0;
        wait_ticks(7);
    endtask

    initial begin
        int seq[4] = '{1, 2, 0, 1};
        i_rst = 1'b1;
        bus.i_ms_pulse = 1'b0;
        bus.i_set = 1'b0; bus.i_up = 1'b0; bus.i_down = 1'b0;
        bus.i_left = 1'b0; bus.i_right = 1'b0;
        repeat (3) cyc();
        check("rst_set_mode", 32'(bus.o_set_mode), 0);
        check("rst_field", 32'(bus.o_field), 0);
        check("rst_blink", 32'(bus.o_blink), 1);
        check("rst_inc", 32'(bus.o_inc), 0);
        check("rst_dec", 32'(bus.o_dec), 0);
        check("rst_commit", 32'(bus.o_commit), 0);
        i_rst = 1'b0;
        repeat (4) cyc();

        // Debounce: short glitch must not enter EDIT.
        bus.i_set = 1'b1;
        wait_ticks(2);
        bus.i_set = 1'b0;
        wait_ticks(3);
        check("glitch_no_edit", 32'(bus.o_set_mode), 0);
        bus.i_set = 1'b1;
        wait_mode(1'b1, 40, n);
        check("edit_entered", 32'(bus.o_set_mode), 1);
        check("edit_entry_latency", 32'(n >= 13 && n <= 15), 1);
        check("blink_on_entry", 32'(bus.o_blink), 1);
        wait_ticks(9);
        check("blink_toggled", 32'(bus.o_blink), 0);

        // Cursor moves.
        for (int i = 0; i < 4; i++) begin
            expect_ev(EV_FIELD, seq[i]);
            press(1'b0, 1'b0, 1'b1, 1'b0);
        end
        expect_ev(EV_FIELD, 0);
        press(1'b0, 1'b0, 1'b0, 1'b1);
        press(1'b0, 1'b0, 1'b1, 1'b1);
        check("field_after_left_right", 32'(bus.o_field), 0);
        expect_ev(EV_FIELD, 1);
        press(1'b0, 1'b0, 1'b1, 1'b0);

        // Increment / decrement, conflicts.
        expect_ev(EV_INC, 1);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        expect_ev(EV_DEC, 1);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b1, 1'b0, 1'b0);
        expect_ev(EV_INC, 1);
        bus.i_up = 1'b1;
        wait_ticks(7);
        bus.i_down = 1'b1;
        wait_ticks(7);
        bus.i_up = 1'b0; bus.i_down = 1'b0;
        wait_ticks(7);

        // Long hold of up.
        for (int i = 0; i < HOLD_PULSES; i++) expect_ev(EV_INC, 1);
        bus.i_up = 1'b1;
        wait_ticks(37);
        bus.i_up = 1'b0;
        wait_ticks(10);
        check("edit_events_drained", exp_q.size(), 0);

        // Commit on set release.
        expect_ev(EV_COMMIT, 1);
        bus.i_set = 1'b0;
        wait_mode(1'b0, 40, n);
        check("commit_exit_edit", 32'(bus.o_set_mode), 0);
        wait_ticks(3);
        check("commit_seen", exp_q.size(), 0);

        // Reset in EDIT aborts without commit.
        expect_ev(EV_FIELD, 0);
        bus.i_set = 1'b1;
        wait_mode(1'b1, 40, n);
        check("edit_reentered", 32'(bus.o_set_mode), 1);
        expect_ev(EV_FIELD, 1);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        i_rst = 1'b1;
        bus.i_set = 1'b0;
        #1;
        check("abort_set_mode", 32'(bus.o_set_mode), 0);
        check("abort_field", 32'(bus.o_field), 0);
        check("abort_blink", 32'(bus.o_blink), 1);
        check("abort_commit", 32'(bus.o_commit), 0);
        repeat (3) cyc();
        i_rst = 1'b0;
        wait_ticks(10);
        check("abort_stays_run", 32'(bus.o_set_mode), 0);
        check("abort_no_events", exp_q.size(), 0);

        // Set fall together with up press: commit only.
        bus.i_set = 1'b1;
        wait_mode(1'b1, 40, n);
        check("edit_third", 32'(bus.o_set_mode), 1);
        expect_ev(EV_COMMIT, 0);
        bus.i_set = 1'b0;
        bus.i_up = 1'b1;
        wait_mode(1'b0, 40, n);
        check("commit_wins_exit", 32'(bus.o_set_mode), 0);
        wait_ticks(3);
        bus.i_up = 1'b0;
        wait_ticks(8);
        check("commit_wins_events", exp_q.size(), 0);
        check("final_run", 32'(bus.o_set_mode), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/clock_set_controller.md
Name: clock_set_controller

Overview:
Front-end controller that sequences time-setting on the clock datapath. It synchronizes and debounces the raw set/up/down/left/right buttons against the shared 1 ms tick. It runs the RUN/EDIT/COMMIT mode machine, moves the edit cursor across the sec/min/hr fields, and issues single-cycle increment/decrement commands, with auto-repeat while a key is held. It sits between the board buttons and the clock counter block.

Parameters:
DEBOUNCE_MS, 4, consecutive ms ticks a synchronized input must differ from its debounced value before the debounced value follows it
HOLD_MS, 500, ms ticks of continuous up/down hold before the first auto-repeat pulse
REPEAT_MS, 100, ms ticks between subsequent auto-repeat pulses
BLINK_MS, 250, ms ticks per half-period of the cursor blink
CNT_W, 16, width of the ms counters; must hold max(HOLD_MS, REPEAT_MS, BLINK_MS, DEBOUNCE_MS)

Ports:
i_clk  input  1  system clock, single clock domain
i_rst  input  1  asynchronous active-high reset
i_ms_pulse  input  1  one-cycle 1 ms tick, synchronous to i_clk
i_set  input  1  raw set switch level; high requests edit mode
i_up  input  1  raw up button
i_down  input  1  raw down button
i_left  input  1  raw left button; moves cursor toward hr
i_right  input  1  raw right button; moves cursor toward sec
o_set_mode  output  1  high in EDIT; the clock datapath freezes its seconds advance
o_field  output  2  cursor: 0=sec, 1=min, 2=hr (3 never driven)
o_inc  output  1  one-cycle increment command for field o_field
o_dec  output  1  one-cycle decrement command for field o_field
o_commit  output  1  one-cycle pulse on leaving EDIT; datapath clears its sub-second count
o_blink  output  1  cursor display enable; toggles in EDIT, constant 1 in RUN

Behaviour:
- Reset (async, active-high): all sync/debounce flops 0, state RUN. Outputs: o_set_mode=0, o_field=0, o_inc=0, o_dec=0, o_commit=0, o_blink=1. All counters 0. Reset mid-EDIT aborts with no o_commit.
- Input path, per button: 2-FF synchronizer, then debouncer. The debounce counter clears on any cycle where sync==deb. On each i_ms_pulse with sync!=deb it increments. On the tick where it reaches DEBOUNCE_MS, deb<=sync and the counter clears.
- Edge detect: press = deb rose this cycle (registered deb_d compare). Commands are registered, so o_inc/o_dec/cursor moves appear the cycle after deb changes.
- FSM RUN: o_set_mode=0. A deb_set rise goes to EDIT with o_field<=0 and the blink counter cleared. Up/down/left/right are ignored.
- FSM EDIT: o_set_mode=1.
  - left press: o_field 0->1->2->0.
  - right press: o_field 0->2->1->0.
  - up press: o_inc. down press: o_dec.
  - deb_set fall goes to COMMIT.
- FSM COMMIT: one cycle, o_commit=1, o_set_mode=0, then RUN. o_field holds its value.
- Simultaneous events:
  - up and down pressed in the same cycle, or either pressed while the other is held: no pulse, and auto-repeat is suppressed until both are released.
  - left and right in the same cycle: cursor unchanged.
  - set falling in the same cycle as an up/down press: COMMIT wins, no inc/dec.
- o_inc and o_dec are never high together. Each is at most one cycle wide per event.
- Blink: in EDIT, o_blink toggles every BLINK_MS ticks, starting at 1. A cursor move reloads it to 1 with the counter cleared. In RUN/COMMIT it is 1.
- Counters saturate at their terminal value. They never wrap.

Optional Feature:
AUTO_REPEAT_EN.
- Defined: while deb_up (or deb_down) stays high in EDIT, the hold counter counts ms ticks. On tick HOLD_MS it emits an extra o_inc (o_dec), then one more every REPEAT_MS ticks until release. Release or a cursor move clears the counter.
- Undefined: exactly one pulse per press. Hold and repeat counters are not instantiated, and HOLD_MS/REPEAT_MS are unused.

Test Plan:
All scenarios use DEBOUNCE_MS=4, HOLD_MS=20, REPEAT_MS=5, BLINK_MS=8, and i_ms_pulse every 3 clocks.
- Reset: assert i_rst mid-cycle -> outputs immediately o_set_mode=0, o_field=0, o_blink=1, o_inc=o_dec=o_commit=0.
- Debounce: i_set glitches high for 2 ticks, then stays high -> no EDIT on the glitch. EDIT is entered, o_set_mode=1, 4 ticks + 3 cycles after the stable rise.
- Cursor: in EDIT, press left 4 times -> o_field sequence 1,2,0,1. Then press right once -> 0. Press left+right together -> no change.
- Inc/dec: in EDIT with o_field=1, press up, then down -> exactly one o_inc then one o_dec pulse, each with o_field=1. Both together -> no pulse.
- Auto-repeat (AUTO_REPEAT_EN): hold up for 37 ticks -> o_inc at press, then at hold ticks 20, 25, 30, 35 (5 pulses total). Without the macro -> 1 pulse.
- Commit/abort: release set -> a single o_commit pulse, then o_set_mode=0. Repeat, but assert i_rst in EDIT -> no o_commit, state RUN.
